// File: rtl/section_sequencer_pkg.sv
// Shared types for the section sequencer: FSM state encoding and direction constants.
package section_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam logic SEQ_ASC  = 1'b0;
  localparam logic SEQ_DESC = 1'b1;

endpackage

// File: rtl/section_sequencer_if.sv
// Control/status bundle of the section sequencer. The dir signal exists only
// when SEQ_REVERSE_EN is defined.
interface section_sequencer_if #(
  parameter int NUM_SECTIONS = 5,
  parameter int CNT_W        = 16
);
  localparam int IDX_W = $clog2(NUM_SECTIONS);

  logic             start;
  logic             oneshot;
  logic [CNT_W-1:0] dwell;
  logic             enable;
  logic             tick;
`ifdef SEQ_REVERSE_EN
  logic             dir;
`endif
  logic [IDX_W-1:0] section;
  logic             busy;
  logic             wrap;
  logic             done;

`ifdef SEQ_REVERSE_EN
  modport master (output start, oneshot, dwell, enable, tick, dir,
                  input  section, busy, wrap, done);
  modport slave  (input  start, oneshot, dwell, enable, tick, dir,
                  output section, busy, wrap, done);
`else
  modport master (output start, oneshot, dwell, enable, tick,
                  input  section, busy, wrap, done);
  modport slave  (input  start, oneshot, dwell, enable, tick,
                  output section, busy, wrap, done);
`endif

endinterface

// File: rtl/section_sequencer_dwell_counter.sv
// Dwell counter: counts enabled strobes up to a terminal value, then rolls to 0.
module dwell_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             at_term
);

  logic [CNT_W-1:0] cnt_q;

  assign at_term = (cnt_q == term);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= at_term ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/section_sequencer.sv
// Section sequencer: steps a section index with a programmable dwell per section,
// cyclic or one-shot. Define SEQ_REVERSE_EN to add the dir input (descending order).
module section_sequencer
  import section_seq_pkg::*;
#(
  parameter int NUM_SECTIONS = 5,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  section_sequencer_if.slave bus
);

  localparam int               IDX_W    = $clog2(NUM_SECTIONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SECTIONS - 1);

  seq_state_t       state_q;
  logic [IDX_W-1:0] section_q;
  logic [CNT_W-1:0] dwell_q;
  logic             oneshot_q;
  logic             dir_q;
  logic             busy_q;
  logic             wrap_q;
  logic             done_q;

  logic             dir_in;
  logic [CNT_W-1:0] term;
  logic             eff_tick;
  logic             at_term;
  logic             at_wrap_pt;

`ifdef SEQ_REVERSE_EN
  assign dir_in = bus.dir;
`else
  assign dir_in = SEQ_ASC;
`endif

  function automatic logic [IDX_W-1:0] first_idx(input logic d);
    return (d == SEQ_DESC) ? LAST_IDX : '0;
  endfunction

  // A latched dwell of 0 behaves as 1, so the terminal count is max(dwell,1)-1.
  assign term       = (dwell_q == '0) ? '0 : dwell_q - CNT_W'(1);
  assign eff_tick   = bus.tick && bus.enable && (state_q == RUN);
  assign at_wrap_pt = (dir_q == SEQ_DESC) ? (section_q == '0) : (section_q == LAST_IDX);

  dwell_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.start),
    .en      (eff_tick && !bus.start),
    .term    (term),
    .at_term (at_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      section_q <= '0;
      dwell_q   <= '0;
      oneshot_q <= 1'b0;
      dir_q     <= SEQ_ASC;
      busy_q    <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.start) begin
        // Start wins over ticks and over the DONE->IDLE return in every state.
        state_q   <= RUN;
        busy_q    <= 1'b1;
        section_q <= first_idx(dir_in);
        dwell_q   <= bus.dwell;
        oneshot_q <= bus.oneshot;
        dir_q     <= dir_in;
      end else begin
        case (state_q)
          RUN: begin
            if (eff_tick && at_term) begin
              if (at_wrap_pt) begin
                if (oneshot_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  section_q <= first_idx(dir_q);
                  wrap_q    <= 1'b1;
                end
              end else if (dir_q == SEQ_DESC) begin
                section_q <= section_q - IDX_W'(1);
              end else begin
                section_q <= section_q + IDX_W'(1);
              end
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.section = section_q;
  assign bus.busy    = busy_q;
  assign bus.wrap    = wrap_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_section_sequencer.sv
// Table-driven bench for section_sequencer (NUM_SECTIONS=5, CNT_W=16); each record
// is applied for one clock and the registered outputs are checked just after the edge.
module tb_section_sequencer;

  logic clk;
  logic reset;

  section_sequencer_if #(.NUM_SECTIONS(5), .CNT_W(16)) bus ();

  section_sequencer #(.NUM_SECTIONS(5), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic        oneshot;
    logic        enable;
    logic        tick;
    logic        dir;
    logic [15:0] dwell;
    logic [2:0]  sec;
    logic        busy;
    logic        wrap;
    logic        done;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input string nm, input logic r, input logic st, input logic os,
                     input logic en, input logic tk, input logic dr, input int dw,
                     input int sec, input logic b, input logic w, input logic dn);
    vec_t v;
    v.name = nm; v.rst = r; v.start = st; v.oneshot = os; v.enable = en;
    v.tick = tk; v.dir = dr; v.dwell = 16'(dw); v.sec = 3'(sec);
    v.busy = b; v.wrap = w; v.done = dn;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [5:0] act, exp;
    reset       = v.rst;
    bus.start   = v.start;
    bus.oneshot = v.oneshot;
    bus.enable  = v.enable;
    bus.tick    = v.tick;
    bus.dwell   = v.dwell;
`ifdef SEQ_REVERSE_EN
    bus.dir     = v.dir;
`endif
    @(posedge clk);
    #1;
    act = {bus.section, bus.busy, bus.wrap, bus.done};
    exp = {v.sec, v.busy, v.wrap, v.done};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got sec=%0d busy=%b wrap=%b done=%b, expected sec=%0d busy=%b wrap=%b done=%b",
               v.name, idx, bus.section, bus.busy, bus.wrap, bus.done,
               v.sec, v.busy, v.wrap, v.done);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.oneshot = 1'b0; bus.enable = 1'b0;
    bus.tick = 1'b0; bus.dwell = '0;
`ifdef SEQ_REVERSE_EN
    bus.dir = 1'b0;
`endif

    //   name        rst st os en tk dr dw  sec busy wrap done
    add("reset",      1, 0, 0, 1, 1, 0, 1,  0, 0, 0, 0);
    add("idle_tick",  0, 0, 0, 1, 1, 0, 1,  0, 0, 0, 0);

    // dwell=1 cycle mode, tick every cycle
    add("cyc1_start", 0, 1, 0, 1, 0, 0, 1,  0, 1, 0, 0);
    for (int k = 1; k <= 6; k++)
      add("cyc1", 0, 0, 0, 1, 1, 0, 1, k % 5, 1, (k == 5), 0);

    // dwell=0 must behave as dwell=1 (restart from RUN)
    add("dw0_start",  0, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0);
    for (int k = 1; k <= 6; k++)
      add("dw0", 0, 0, 0, 1, 1, 0, 0, k % 5, 1, (k == 5), 0);

    // dwell=3 one-shot, 15 ticks, then IDLE ignores ticks
    add("os3_start",  0, 1, 1, 1, 0, 0, 3,  0, 1, 0, 0);
    for (int k = 1; k <= 15; k++)
      add("os3", 0, 0, 0, 1, 1, 0, 0, (k == 15) ? 4 : k / 3, (k != 15), 0, (k == 15));
    add("os3_idle",   0, 0, 0, 1, 0, 0, 0,  4, 0, 0, 0);
    add("os3_idletk", 0, 0, 0, 1, 1, 0, 0,  4, 0, 0, 0);

    // start in the DONE cycle restarts
    add("os1_start",  0, 1, 1, 1, 0, 0, 1,  0, 1, 0, 0);
    for (int k = 1; k <= 5; k++)
      add("os1", 0, 0, 0, 1, 1, 0, 1, (k == 5) ? 4 : k, (k != 5), 0, (k == 5));
    add("done_restart", 0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 0);
    add("after_restart", 0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 0);

    // enable low mid-dwell freezes the count
    add("en_start",   0, 1, 0, 1, 0, 0, 3,  0, 1, 0, 0);
    add("en_tick1",   0, 0, 0, 1, 1, 0, 3,  0, 1, 0, 0);
    for (int k = 0; k < 4; k++)
      add("en_hold", 0, 0, 0, 0, 1, 0, 3, 0, 1, 0, 0);
    add("en_tick2",   0, 0, 0, 1, 1, 0, 3,  0, 1, 0, 0);
    add("en_tick3",   0, 0, 0, 1, 1, 0, 3,  1, 1, 0, 0);

    // start coincident with a tick at section 3, dwell=2
    add("rs_start",   0, 1, 0, 1, 0, 0, 2,  0, 1, 0, 0);
    for (int k = 1; k <= 7; k++)
      add("rs_run", 0, 0, 0, 1, 1, 0, 2, k / 2, 1, 0, 0);
    add("rs_restart", 0, 1, 0, 1, 1, 0, 2,  0, 1, 0, 0);
    add("rs_cnt0",    0, 0, 0, 1, 1, 0, 2,  0, 1, 0, 0);
    add("rs_cnt1",    0, 0, 0, 1, 1, 0, 2,  1, 1, 0, 0);
    add("rs_run2",    0, 0, 0, 1, 1, 0, 2,  1, 1, 0, 0);

    // reset mid-RUN
    add("rst_mid",    1, 0, 0, 1, 1, 0, 2,  0, 0, 0, 0);
    add("rst_idle",   0, 0, 0, 1, 1, 0, 2,  0, 0, 0, 0);

`ifdef SEQ_REVERSE_EN
    // descending, dwell=1, cycle mode
    add("rev_start",  0, 1, 0, 1, 0, 1, 1,  4, 1, 0, 0);
    add("rev",        0, 0, 0, 1, 1, 0, 1,  3, 1, 0, 0);
    add("rev",        0, 0, 0, 1, 1, 0, 1,  2, 1, 0, 0);
    add("rev",        0, 0, 0, 1, 1, 0, 1,  1, 1, 0, 0);
    add("rev",        0, 0, 0, 1, 1, 0, 1,  0, 1, 0, 0);
    add("rev_wrap",   0, 0, 0, 1, 1, 0, 1,  4, 1, 1, 0);
    add("rev",        0, 0, 0, 1, 1, 0, 1,  3, 1, 0, 0);
`endif

    foreach (vecs[i]) apply(vecs[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/section_sequencer.md
# section_sequencer

Parametrised section sequencer for the VGA display path. It steps a section index through `NUM_SECTIONS` positions, dwelling a programmable number of strobe ticks on each one. It supports continuous cycling or a one-shot pass, a pause via enable, and restart. It generalises the fixed five-state cyclic section FSM and drives section selection in the pixel/pattern generator. Its strobe `tick` is normally the frame-start or line-start pulse from the timing generator.

## Interface
- `NUM_SECTIONS`, default 5: number of sections; legal range is 2 or more.
- `CNT_W`, default 16: width of the dwell count.
- `IDX_W`, derived local constant `$clog2(NUM_SECTIONS)`: width of the section index.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: single-cycle pulse; begins or restarts a sequence.
- `oneshot`  in  1: 0 = cycle forever, 1 = single pass; sampled on `start`.
- `dwell`  in  `CNT_W`: ticks per section; sampled on `start`; 0 is treated as 1.
- `enable`  in  1: when 0, ticks are ignored and the sequence pauses.
- `tick`  in  1: advance strobe.
- `dir`  in  1: 0 = ascending, 1 = descending; present only with `SEQ_REVERSE_EN`.
- `section`  out  `IDX_W`: current section index.
- `busy`  out  1: high while in RUN.
- `wrap`  out  1: one-cycle pulse when the index wraps in cycle mode.
- `done`  out  1: one-cycle pulse when a one-shot pass completes.

## Operation
- FSM states are IDLE, RUN and DONE. Reset puts the block in IDLE with `section`=0, dwell counter=0, and `busy`, `wrap`, `done` all 0.
- **IDLE**
  - `tick` is ignored.
  - `start` moves the FSM to RUN.
  - On that transition: `section` is set to the first index, the counter is cleared, and `dwell`, `oneshot` and `dir` are latched.
- **RUN**
  - `busy`=1.
  - A cycle with `tick`&&`enable` is an effective tick.
  - If counter == `dwell_eff`−1: clear the counter and advance the section. Otherwise, increment the counter.
  - `dwell_eff` = max(latched `dwell`, 1).
- **Advance, ascending:** `NUM_SECTIONS`−1 wraps to 0. **Advance, descending:** 0 wraps to `NUM_SECTIONS`−1. Any other index steps by ±1.
- **At a wrap point, cycle mode:** the index wraps and `wrap` pulses for one cycle.
- **At a wrap point, one-shot mode:** `section` holds the last index, the FSM moves to DONE, and `wrap` does not pulse.
- **DONE**
  - `done`=1 for exactly this one cycle and `busy`=0.
  - The next state is IDLE, and `section` keeps the last index.
  - `start` in DONE moves the FSM to RUN (restart), taking priority over the return to IDLE.
- **`start` while in RUN:** immediate restart. The index returns to the first value, the counter clears, and inputs are re-latched. `start` has priority over a simultaneous tick.
- **`enable`=0 in RUN:** the counter and index freeze. `start` is still honoured.
- **Reset** overrides everything, including a mid-sequence RUN, and returns the block to IDLE with reset values.
- **Counter width:** the counter is `CNT_W` bits and never exceeds `dwell_eff`−1, so no overflow is possible.
- **First index:** 0 when ascending, `NUM_SECTIONS`−1 when descending.

## Timing
- All outputs are registered.
- **Index latency:** `section` changes in the cycle after the effective tick that completes a dwell. `wrap` asserts in that same cycle.
- **Start latency:** `busy` rises in the cycle after `start`.
- **Done latency:** `done` asserts in the cycle after the final effective tick, and `busy` falls in that same cycle.
- **Pass length:** a one-shot pass takes exactly `NUM_SECTIONS`×`dwell_eff` effective ticks.
- **Inputs:** `tick` may be asserted on consecutive cycles. `start`, `dwell` and `oneshot` need no holding beyond the `start` cycle.

## Configuration
- `SEQ_REVERSE_EN`
  - **Defined:** the `dir` port exists and descending order is supported.
  - **Undefined:** the `dir` port is absent and order is always ascending, with first index 0.

## Structure
- Package `section_seq_pkg` holds:
  - `seq_state_t`, an enum of IDLE/RUN/DONE;
  - the `SEQ_ASC`/`SEQ_DESC` direction constants.
- Sub-module `dwell_counter`, parametrised by `CNT_W`:
  - inputs: load/clear, count-enable, terminal value;
  - output: a terminal-count flag.
- The top level holds the FSM and the index register.

## Test plan
- `NUM_SECTIONS`=5, `dwell`=1, cycle mode, `tick` every cycle:
  - `section` runs 0,1,2,3,4,0,1;
  - `wrap` pulses once, in the cycle `section` returns to 0.
- `dwell`=3, one-shot, 15 ticks:
  - `section` changes every 3 ticks, ending at 4;
  - `done` is high for one cycle, then `busy`=0 and the FSM returns to IDLE with `section`=4.
- `dwell`=0:
  - behaves exactly as `dwell`=1.
- `enable` dropped for 4 cycles mid-dwell with ticks present:
  - `section` and the counter hold;
  - the sequence resumes on the same count after re-enable.
- `start` pulsed at `section`=3, coincident with a tick; also reset asserted mid-RUN:
  - the `start` case restarts at 0 with the counter cleared;
  - the reset case yields IDLE, `section`=0 and all pulse outputs 0.
- With `SEQ_REVERSE_EN` defined, `dir`=1, `dwell`=1, cycle mode:
  - `section` runs 4,3,2,1,0,4;
  - `wrap` pulses when `section` goes to 4.
